// File: rtl/mem_access_master_pkg.sv
// Shared widths, FSM encoding and address helper for the cache<->DRAM block
// access master.
package mem_access_master_pkg;

   localparam int unsigned BlockW   = 128;
   localparam int unsigned AddrW    = 32;
   localparam int unsigned BlockOfs = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StResp  = 2'd3
   } state_e;

   function automatic logic [AddrW-1:0] block_align(input logic [AddrW-1:0] addr);
      return addr & {{(AddrW-BlockOfs){1'b1}}, {BlockOfs{1'b0}}};
   endfunction

endpackage

// File: rtl/mem_access_master_if.sv
// Pin bundle between the access master and main_memory.
interface mem_access_master_if;
   import mem_access_master_pkg::*;

   logic              mem_read;
   logic              mem_write;
   logic              mem_wait_access;
   logic [AddrW-1:0]  mem_read_address;
   logic [AddrW-1:0]  mem_write_address;
   logic [BlockW-1:0] mem_write_data;
   logic [BlockW-1:0] mem_read_data;
   logic              mem_ready;

   modport master (
      output mem_read, mem_write, mem_wait_access,
      output mem_read_address, mem_write_address, mem_write_data,
      input  mem_read_data, mem_ready
   );

   modport slave (
      input  mem_read, mem_write, mem_wait_access,
      input  mem_read_address, mem_write_address, mem_write_data,
      output mem_read_data, mem_ready
   );

endinterface

// File: rtl/mem_access_master_watchdog.sv
// Cycle counter that flags a DRAM access running for TimeoutCycles cycles.
module mem_access_master_watchdog #(
   parameter int unsigned TimeoutCycles = 64,
   parameter int unsigned CntW          = 7
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires in the cycle whose increment would bring the count to TimeoutCycles.
   assign expired_o = en_i && (cnt_q == CntW'(TimeoutCycles - 1));

endmodule

// File: rtl/mem_access_master.sv
// Block-transfer initiator for main_memory: one refill and/or evict per request,
// registered pin drive, MemReady tracking and a watchdog abort.
module mem_access_master
   import mem_access_master_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 64,
   parameter int unsigned CntW          = 7
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_load_i,
   input  logic              req_evict_i,
   input  logic [AddrW-1:0]  req_load_addr_i,
   input  logic [AddrW-1:0]  req_evict_addr_i,
   input  logic [BlockW-1:0] req_evict_block_i,
   output logic              resp_valid_o,
   output logic [BlockW-1:0] resp_block_o,
   output logic              resp_error_o,
   mem_access_master_if.master bus
);

   state_e            state_q, state_d;
   logic              en_q;
   logic              rd_q, rd_d, wr_q, wr_d, strobe_q, strobe_d, err_q, err_d;
   logic [AddrW-1:0]  raddr_q, raddr_d, waddr_q, waddr_d;
   logic [BlockW-1:0] wdata_q, wdata_d, blk_q, blk_d;
   logic              resp_valid_q, resp_valid_d, resp_error_q, resp_error_d;
   logic              wd_clear, wd_en, wd_expired;

   // en_q keeps req_ready low while reset is applied and for the first edge after.
   assign req_ready_o = (state_q == StIdle) && en_q && bus.mem_ready;

   mem_access_master_watchdog #(
      .TimeoutCycles(TimeoutCycles),
      .CntW         (CntW)
   ) u_watchdog (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (wd_clear),
      .en_i     (wd_en),
      .expired_o(wd_expired)
   );

   always_comb begin
      state_d      = state_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      strobe_d     = strobe_q;
      err_d        = err_q;
      raddr_d      = raddr_q;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      blk_d        = blk_q;
      resp_valid_d = 1'b0;
      resp_error_d = 1'b0;
      wd_clear     = 1'b0;
      wd_en        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i && req_ready_o) begin
               raddr_d = block_align(req_load_addr_i);
               waddr_d = block_align(req_evict_addr_i);
               wdata_d = req_evict_block_i;
               err_d   = 1'b0;
               if (req_load_i || req_evict_i) begin
                  rd_d     = req_load_i;
                  wr_d     = req_evict_i;
                  strobe_d = 1'b1;
                  wd_clear = 1'b1;
                  state_d  = StIssue;
               end else begin
                  state_d = StResp;
               end
            end
         end
         StIssue, StWait: begin
            wd_en = 1'b1;
            if (wd_expired) begin
               err_d    = 1'b1;
               strobe_d = 1'b0;
               rd_d     = 1'b0;
               wr_d     = 1'b0;
               state_d  = StResp;
            end else if (state_q == StIssue) begin
               // Strobe must drop once DRAM has taken the access, or it restarts.
               if (!bus.mem_ready) begin
                  strobe_d = 1'b0;
                  state_d  = StWait;
               end
            end else if (bus.mem_ready) begin
               if (rd_q) begin
                  blk_d = bus.mem_read_data;
               end
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = StResp;
            end
         end
         StResp: begin
            resp_valid_d = 1'b1;
            resp_error_d = err_q;
            state_d      = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         en_q         <= 1'b0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         strobe_q     <= 1'b0;
         err_q        <= 1'b0;
         raddr_q      <= '0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         blk_q        <= '0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         en_q         <= 1'b1;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         strobe_q     <= strobe_d;
         err_q        <= err_d;
         raddr_q      <= raddr_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         blk_q        <= blk_d;
         resp_valid_q <= resp_valid_d;
         resp_error_q <= resp_error_d;
      end
   end

   assign bus.mem_read          = rd_q;
   assign bus.mem_write         = wr_q;
   assign bus.mem_wait_access   = strobe_q;
   assign bus.mem_read_address  = raddr_q;
   assign bus.mem_write_address = waddr_q;
   assign bus.mem_write_data    = wdata_q;
   assign resp_valid_o          = resp_valid_q;
   assign resp_error_o          = resp_error_q;
   assign resp_block_o          = blk_q;

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: behavioural DRAM slave, transaction-level
// reference model checked every cycle, plus directed literal checks.
module tb_mem_access_master;
   import mem_access_master_pkg::*;

   localparam int Timeout = 64;
   localparam int Acc     = 5;
   localparam int RamN    = 1024;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         req_valid = 1'b0, req_ready, req_load = 1'b0, req_evict = 1'b0;
   logic [31:0]  req_load_addr = '0, req_evict_addr = '0;
   logic [127:0] req_evict_block = '0;
   logic         resp_valid, resp_error;
   logic [127:0] resp_block;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_access_master_if bus ();

   mem_access_master #(
      .TimeoutCycles(Timeout),
      .CntW         (7)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .req_valid_i      (req_valid),
      .req_ready_o      (req_ready),
      .req_load_i       (req_load),
      .req_evict_i      (req_evict),
      .req_load_addr_i  (req_load_addr),
      .req_evict_addr_i (req_evict_addr),
      .req_evict_block_i(req_evict_block),
      .resp_valid_o     (resp_valid),
      .resp_block_o     (resp_block),
      .resp_error_o     (resp_error),
      .bus              (bus)
   );

   function automatic logic [127:0] pat(input int i);
      return {32'hC0DE_0000, 64'h0, 32'(i)};
   endfunction

   function automatic int idx(input logic [31:0] a);
      return int'(a[13:4]);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // main_memory stand-in: takes the strobe, drops ready for Acc edges, then
   // performs read and write together with nonblocking semantics.
   logic [127:0] ram [RamN];
   logic         ram_init = 1'b0;
   logic         d_ready = 1'b1, d_busy = 1'b0;
   logic [127:0] d_rdata = '0;
   int           d_cnt = 0;
   logic         dram_hang = 1'b0, dram_release = 1'b0;

   assign bus.mem_ready     = d_ready;
   assign bus.mem_read_data = d_rdata;

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < RamN; i++) ram[i] <= pat(i);
         ram[12'h123] <= 128'h0123_4567_89AB_CDEF_0000_1111_2222_AA55;
         ram_init <= 1'b1;
      end else if (dram_release) begin
         d_busy  <= 1'b0;
         d_ready <= 1'b1;
      end else if (!d_busy) begin
         if (bus.mem_wait_access) begin
            d_busy  <= 1'b1;
            d_ready <= 1'b0;
            d_cnt   <= Acc;
         end
      end else if (!dram_hang) begin
         if (d_cnt == 1) begin
            if (bus.mem_read) d_rdata <= ram[idx(bus.mem_read_address)];
            if (bus.mem_write) ram[idx(bus.mem_write_address)] <= bus.mem_write_data;
            d_ready <= 1'b1;
            d_busy  <= 1'b0;
         end else begin
            d_cnt <= d_cnt - 1;
         end
      end
   end

   // Reference model: one outstanding transaction, response R edges after accept.
   logic         m_en, m_busy, m_load, m_evict, m_err, m_resp, m_acc;
   int           m_k, m_r;
   logic [31:0]  m_la, m_ea;
   logic [127:0] m_wd, m_exp, m_blk;
   logic [127:0] ref_mem [RamN];
   logic         ref_init = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_en   <= 1'b0;
         m_busy <= 1'b0;
         m_resp <= 1'b0;
         m_acc  <= 1'b0;
         m_blk  <= '0;
         m_k    <= 0;
         m_r    <= 0;
         m_load <= 1'b0;
         m_evict <= 1'b0;
         m_err  <= 1'b0;
      end else begin
         m_en   <= 1'b1;
         m_resp <= 1'b0;
         m_acc  <= 1'b0;
         if (!ref_init) begin
            for (int i = 0; i < RamN; i++) ref_mem[i] <= pat(i);
            ref_mem[12'h123] <= 128'h0123_4567_89AB_CDEF_0000_1111_2222_AA55;
            ref_init <= 1'b1;
         end
         if (m_busy) begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_r) begin
               m_busy <= 1'b0;
               m_resp <= 1'b1;
               if (m_load && !m_err) m_blk <= m_exp;
            end
         end else if (m_en && bus.mem_ready && req_valid) begin
            m_acc   <= 1'b1;
            m_busy  <= 1'b1;
            m_k     <= 0;
            m_load  <= req_load;
            m_evict <= req_evict;
            m_la    <= req_load_addr & ~32'hF;
            m_ea    <= req_evict_addr & ~32'hF;
            m_wd    <= req_evict_block;
            m_exp   <= ref_mem[idx(req_load_addr)];
            if (!(req_load || req_evict)) begin
               m_r   <= 1;
               m_err <= 1'b0;
            end else if (dram_hang) begin
               m_r   <= Timeout + 1;
               m_err <= 1'b1;
            end else begin
               m_r   <= Acc + 3;
               m_err <= 1'b0;
               if (req_evict) ref_mem[idx(req_evict_addr)] <= req_evict_block;
            end
         end
      end
   end

   logic m_active, exp_ready, exp_strobe, exp_rd, exp_wr;
   assign m_active   = m_busy && (m_load || m_evict);
   assign exp_ready  = m_en && !m_busy && bus.mem_ready;
   assign exp_strobe = m_active && (m_k < 2);
   assign exp_rd     = m_active && m_load && (m_k <= m_r - 2);
   assign exp_wr     = m_active && m_evict && (m_k <= m_r - 2);

   always @(negedge clk) begin
      chk("req_ready", req_ready, exp_ready);
      chk("mem_wait_access", bus.mem_wait_access, exp_strobe);
      chk("mem_read", bus.mem_read, exp_rd);
      chk("mem_write", bus.mem_write, exp_wr);
      if (exp_rd) chk("mem_read_address", bus.mem_read_address, m_la);
      if (exp_wr) begin
         chk("mem_write_address", bus.mem_write_address, m_ea);
         chk("mem_write_data", bus.mem_write_data, m_wd);
      end
      chk("resp_valid", resp_valid, m_resp);
      chk("resp_error", resp_error, m_resp && m_err);
      if (m_resp) chk("resp_block", resp_block, m_blk);
   end

   task automatic run_req(input logic ld, input logic ev, input logic [31:0] la,
                          input logic [31:0] ea, input logic [127:0] blk,
                          output int lat, output int strobes, output int pulses,
                          output logic [127:0] rblk, output logic rerr,
                          output logic [31:0] raddr);
      bit got = 0;
      lat = 0; strobes = 0; pulses = 0; rblk = '0; rerr = 1'b0; raddr = '0;
      req_valid = 1'b1; req_load = ld; req_evict = ev;
      req_load_addr = la; req_evict_addr = ea; req_evict_block = blk;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk); #1;
         got = m_acc;
      end
      req_valid = 1'b0;
      chk("accepted", got, 1'b1);
      if (got) begin
         raddr = bus.mem_read_address;
         if (bus.mem_wait_access) strobes++;
         for (int i = 1; i <= Timeout + 10; i++) begin
            @(posedge clk); #1;
            if (bus.mem_wait_access) strobes++;
            if (resp_valid) begin
               pulses++;
               if (lat == 0) begin
                  lat = i; rblk = resp_block; rerr = resp_error;
               end
            end
            if (lat != 0 && i >= lat + 2) break;
         end
      end
   endtask

   int           lat, strobes, pulses;
   logic [127:0] rblk;
   logic         rerr;
   logic [31:0]  raddr;

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset req_ready", req_ready, 1'b0);
      chk("reset resp_valid", resp_valid, 1'b0);
      chk("reset mem_wait_access", bus.mem_wait_access, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Load only
      run_req(1'b1, 1'b0, 32'h0000_1234, 32'h0, '0, lat, strobes, pulses, rblk, rerr, raddr);
      chk("load latency", lat, 8);
      chk("load read_address", raddr, 32'h0000_1230);
      chk("load block", rblk, 128'h0123_4567_89AB_CDEF_0000_1111_2222_AA55);
      chk("load error", rerr, 1'b0);
      chk("load pulses", pulses, 1);
      chk("load strobes", strobes, 2);

      // Evict only, then read it back
      run_req(1'b0, 1'b1, 32'h0, 32'h40, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF,
              lat, strobes, pulses, rblk, rerr, raddr);
      chk("evict latency", lat, 8);
      chk("evict strobes", strobes, 2);
      chk("evict pulses", pulses, 1);
      run_req(1'b1, 1'b0, 32'h40, 32'h0, '0, lat, strobes, pulses, rblk, rerr, raddr);
      chk("evict readback", rblk, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);

      // Combined evict + load of the same block: pre-write contents come back
      run_req(1'b1, 1'b1, 32'h80, 32'h80, {4{32'h1111_1111}},
              lat, strobes, pulses, rblk, rerr, raddr);
      chk("combined block", rblk, 128'hC0DE_0000_0000_0000_0000_0000_0000_0008);
      chk("combined strobes", strobes, 2);
      chk("combined latency", lat, 8);
      run_req(1'b1, 1'b0, 32'h8C, 32'h0, '0, lat, strobes, pulses, rblk, rerr, raddr);
      chk("combined readback", rblk, {4{32'h1111_1111}});

      // Zero-op
      run_req(1'b0, 1'b0, 32'h0, 32'h0, '0, lat, strobes, pulses, rblk, rerr, raddr);
      chk("zero-op latency", lat, 1);
      chk("zero-op strobes", strobes, 0);
      chk("zero-op pulses", pulses, 1);
      chk("zero-op block kept", rblk, {4{32'h1111_1111}});

      // Hung DRAM: watchdog abort
      dram_hang = 1'b1;
      run_req(1'b1, 1'b1, 32'h100, 32'h110, {4{32'h7777_7777}},
              lat, strobes, pulses, rblk, rerr, raddr);
      chk("timeout latency", lat, 65);
      chk("timeout error", rerr, 1'b1);
      chk("timeout pulses", pulses, 1);
      chk("timeout block kept", rblk, {4{32'h1111_1111}});
      chk("timeout req_ready low", req_ready, 1'b0);
      dram_release = 1'b1;
      @(posedge clk); #1;
      dram_release = 1'b0;
      dram_hang    = 1'b0;
      chk("timeout req_ready back", req_ready, 1'b1);
      run_req(1'b1, 1'b0, 32'h110, 32'h0, '0, lat, strobes, pulses, rblk, rerr, raddr);
      chk("timeout no write", rblk, 128'hC0DE_0000_0000_0000_0000_0000_0000_0011);

      // Reset while waiting on DRAM
      req_valid = 1'b1; req_load = 1'b1; req_evict = 1'b0; req_load_addr = 32'h300;
      begin
         bit got = 0;
         for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk); #1;
            got = m_acc;
         end
         chk("abort accepted", got, 1'b1);
      end
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort mem_wait_access", bus.mem_wait_access, 1'b0);
      chk("abort mem_read", bus.mem_read, 1'b0);
      chk("abort read_address", bus.mem_read_address, 32'h0);
      chk("abort req_ready", req_ready, 1'b0);
      chk("abort resp_block", resp_block, 128'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_req(1'b1, 1'b0, 32'h300, 32'h0, '0, lat, strobes, pulses, rblk, rerr, raddr);
      chk("post-reset block", rblk, 128'hC0DE_0000_0000_0000_0000_0000_0000_0030);
      chk("post-reset latency", lat, 8);
      chk("post-reset error", rerr, 1'b0);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "bench time limit");
   end

endmodule
